// File: rtl/mem_bus_pkg.sv
// Shared definitions for the memory-side bus: default widths, AXI response
// codes, the arbiter state encoding and the read-master identifiers.
package mem_bus_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 64;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        IDLE,
        RD_IFU,
        RD_LSU,
        WR
    } arb_state_e;

    typedef enum logic {
        M_IFU,
        M_LSU
    } master_id_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin picker for the read masters.
// Ports:
//   aclk, aresetn  clock / async active-low reset
//   req_ifu        IFU read request
//   req_lsu        LSU read request
//   update         commit the current grant as the most recent read grant
//   grant          master picked among the active requests
module rr_arb2
    import mem_bus_pkg::*;
(
    input  logic       aclk,
    input  logic       aresetn,
    input  logic       req_ifu,
    input  logic       req_lsu,
    input  logic       update,
    output master_id_e grant
);

    // Reset to IFU so that the first contested read goes to the LSU.
    master_id_e last_rd_grant_q;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            last_rd_grant_q <= M_IFU;
        end else if (update) begin
            last_rd_grant_q <= grant;
        end
    end

    always_comb begin
        if (req_ifu && req_lsu) begin
            grant = (last_rd_grant_q == M_IFU) ? M_LSU : M_IFU;
        end else if (req_lsu) begin
            grant = M_LSU;
        end else begin
            grant = M_IFU;
        end
    end

endmodule

// File: rtl/axi_mem_arbiter.sv
// Two-master (IFU read, LSU read/write) to one-slave AXI4-lite arbiter in front
// of the SRAM model. One transaction in flight at a time; a complete LSU write
// request beats reads, reads are granted round-robin.
// Ports:
//   aclk, aresetn      clock / async active-low reset
//   ifu_ar*, ifu_r*    IFU read-address and read-data channels
//   lsu_ar*, lsu_r*    LSU read-address and read-data channels
//   lsu_aw*, lsu_w*    LSU write-address and write-data channels
//   lsu_b*             LSU write-response channel
//   mem_*              slave port toward the SRAM (mirrored directions)
module axi_mem_arbiter #(
    parameter int unsigned ADDR_W = mem_bus_pkg::ADDR_W,
    parameter int unsigned DATA_W = mem_bus_pkg::DATA_W
) (
    input  logic                aclk,
    input  logic                aresetn,
    input  logic [ADDR_W-1:0]   ifu_araddr,
    input  logic                ifu_arvalid,
    output logic                ifu_arready,
    output logic [DATA_W-1:0]   ifu_rdata,
    output logic [1:0]          ifu_rresp,
    output logic                ifu_rvalid,
    input  logic                ifu_rready,
    input  logic [ADDR_W-1:0]   lsu_araddr,
    input  logic                lsu_arvalid,
    output logic                lsu_arready,
    output logic [DATA_W-1:0]   lsu_rdata,
    output logic [1:0]          lsu_rresp,
    output logic                lsu_rvalid,
    input  logic                lsu_rready,
    input  logic [ADDR_W-1:0]   lsu_awaddr,
    input  logic                lsu_awvalid,
    output logic                lsu_awready,
    input  logic [DATA_W-1:0]   lsu_wdata,
    input  logic [DATA_W/8-1:0] lsu_wstrb,
    input  logic                lsu_wvalid,
    output logic                lsu_wready,
    output logic [1:0]          lsu_bresp,
    output logic                lsu_bvalid,
    input  logic                lsu_bready,
    output logic [ADDR_W-1:0]   mem_araddr,
    output logic                mem_arvalid,
    input  logic                mem_arready,
    input  logic [DATA_W-1:0]   mem_rdata,
    input  logic [1:0]          mem_rresp,
    input  logic                mem_rvalid,
    output logic                mem_rready,
    output logic [ADDR_W-1:0]   mem_awaddr,
    output logic                mem_awvalid,
    input  logic                mem_awready,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_wstrb,
    output logic                mem_wvalid,
    input  logic                mem_wready,
    input  logic [1:0]          mem_bresp,
    input  logic                mem_bvalid,
    output logic                mem_bready
);

    import mem_bus_pkg::*;

    arb_state_e state_q, state_d;
    logic       ar_done_q, ar_done_d;
    logic       aw_done_q, aw_done_d;
    logic       w_done_q, w_done_d;
    logic       wr_req, rd_req, grant_update, wr_both_done;
    logic       ar_hs, r_hs, aw_hs, w_hs, b_hs;
    master_id_e rd_grant;

    assign wr_req       = lsu_awvalid & lsu_wvalid;
    assign rd_req       = ifu_arvalid | lsu_arvalid;
    assign grant_update = (state_q == IDLE) & ~wr_req & rd_req;
    assign wr_both_done = aw_done_q & w_done_q;

    assign ar_hs = mem_arvalid & mem_arready;
    assign r_hs  = mem_rvalid & mem_rready;
    assign aw_hs = mem_awvalid & mem_awready;
    assign w_hs  = mem_wvalid & mem_wready;
    assign b_hs  = mem_bvalid & mem_bready;

    rr_arb2 u_rr_arb2 (
        .aclk    (aclk),
        .aresetn (aresetn),
        .req_ifu (ifu_arvalid),
        .req_lsu (lsu_arvalid),
        .update  (grant_update),
        .grant   (rd_grant)
    );

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q   <= IDLE;
            ar_done_q <= 1'b0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            ar_done_q <= ar_done_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        ar_done_d = ar_done_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        unique case (state_q)
            IDLE: begin
                if (wr_req) begin
                    state_d = WR;
                end else if (rd_req) begin
                    state_d = (rd_grant == M_LSU) ? RD_LSU : RD_IFU;
                end
            end
            RD_IFU, RD_LSU: begin
                if (ar_hs) ar_done_d = 1'b1;
                // R may complete in the same cycle as AR; the clear wins.
                if (r_hs) begin
                    state_d   = IDLE;
                    ar_done_d = 1'b0;
                end
            end
            WR: begin
                if (aw_hs) aw_done_d = 1'b1;
                if (w_hs)  w_done_d  = 1'b1;
                if (b_hs) begin
                    state_d   = IDLE;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ifu_arready = 1'b0;
        ifu_rdata   = '0;
        ifu_rresp   = '0;
        ifu_rvalid  = 1'b0;
        lsu_arready = 1'b0;
        lsu_rdata   = '0;
        lsu_rresp   = '0;
        lsu_rvalid  = 1'b0;
        lsu_awready = 1'b0;
        lsu_wready  = 1'b0;
        lsu_bresp   = '0;
        lsu_bvalid  = 1'b0;
        mem_araddr  = '0;
        mem_arvalid = 1'b0;
        mem_rready  = 1'b0;
        mem_awaddr  = '0;
        mem_awvalid = 1'b0;
        mem_wdata   = '0;
        mem_wstrb   = '0;
        mem_wvalid  = 1'b0;
        mem_bready  = 1'b0;
        unique case (state_q)
            RD_IFU: begin
                mem_araddr  = ifu_araddr;
                mem_arvalid = ifu_arvalid & ~ar_done_q;
                ifu_arready = mem_arready & ~ar_done_q;
                ifu_rvalid  = mem_rvalid;
                mem_rready  = ifu_rready;
            end
            RD_LSU: begin
                mem_araddr  = lsu_araddr;
                mem_arvalid = lsu_arvalid & ~ar_done_q;
                lsu_arready = mem_arready & ~ar_done_q;
                lsu_rvalid  = mem_rvalid;
                mem_rready  = lsu_rready;
            end
            WR: begin
                mem_awaddr  = lsu_awaddr;
                mem_awvalid = lsu_awvalid & ~aw_done_q;
                lsu_awready = mem_awready & ~aw_done_q;
                mem_wdata   = lsu_wdata;
                mem_wstrb   = lsu_wstrb;
                mem_wvalid  = lsu_wvalid & ~w_done_q;
                lsu_wready  = mem_wready & ~w_done_q;
                // B is only meaningful once both AW and W have left.
                lsu_bresp   = mem_bresp;
                lsu_bvalid  = mem_bvalid & wr_both_done;
                mem_bready  = lsu_bready & wr_both_done;
            end
            default: ;
        endcase
        // Read data is broadcast; only the granted master sees rvalid.
        if (state_q == RD_IFU || state_q == RD_LSU) begin
            ifu_rdata = mem_rdata;
            ifu_rresp = mem_rresp;
            lsu_rdata = mem_rdata;
            lsu_rresp = mem_rresp;
        end
    end

endmodule

// File: tb/tb_axi_mem_arbiter.sv
// Randomized bench for axi_mem_arbiter: IFU/LSU master agents, a memory slave
// agent and a transaction-level model of grant order and channel routing.
module tb_axi_mem_arbiter;
    import mem_bus_pkg::*;

    localparam int unsigned AW = mem_bus_pkg::ADDR_W;
    localparam int unsigned DW = mem_bus_pkg::DATA_W;
    localparam int unsigned SW = DW / 8;
    localparam int C_NONE = 0, C_RI = 1, C_RL = 2, C_WR = 3;

    logic aclk, aresetn;
    logic [AW-1:0] ifu_araddr, lsu_araddr, lsu_awaddr, mem_araddr, mem_awaddr;
    logic ifu_arvalid, ifu_arready, ifu_rvalid, ifu_rready;
    logic lsu_arvalid, lsu_arready, lsu_rvalid, lsu_rready;
    logic lsu_awvalid, lsu_awready, lsu_wvalid, lsu_wready, lsu_bvalid, lsu_bready;
    logic mem_arvalid, mem_arready, mem_rvalid, mem_rready;
    logic mem_awvalid, mem_awready, mem_wvalid, mem_wready, mem_bvalid, mem_bready;
    logic [DW-1:0] ifu_rdata, lsu_rdata, lsu_wdata, mem_rdata, mem_wdata;
    logic [SW-1:0] lsu_wstrb, mem_wstrb;
    logic [1:0] ifu_rresp, lsu_rresp, lsu_bresp, mem_rresp, mem_bresp;

    axi_mem_arbiter dut (
        .aclk(aclk), .aresetn(aresetn),
        .ifu_araddr(ifu_araddr), .ifu_arvalid(ifu_arvalid), .ifu_arready(ifu_arready),
        .ifu_rdata(ifu_rdata), .ifu_rresp(ifu_rresp), .ifu_rvalid(ifu_rvalid),
        .ifu_rready(ifu_rready),
        .lsu_araddr(lsu_araddr), .lsu_arvalid(lsu_arvalid), .lsu_arready(lsu_arready),
        .lsu_rdata(lsu_rdata), .lsu_rresp(lsu_rresp), .lsu_rvalid(lsu_rvalid),
        .lsu_rready(lsu_rready),
        .lsu_awaddr(lsu_awaddr), .lsu_awvalid(lsu_awvalid), .lsu_awready(lsu_awready),
        .lsu_wdata(lsu_wdata), .lsu_wstrb(lsu_wstrb), .lsu_wvalid(lsu_wvalid),
        .lsu_wready(lsu_wready),
        .lsu_bresp(lsu_bresp), .lsu_bvalid(lsu_bvalid), .lsu_bready(lsu_bready),
        .mem_araddr(mem_araddr), .mem_arvalid(mem_arvalid), .mem_arready(mem_arready),
        .mem_rdata(mem_rdata), .mem_rresp(mem_rresp), .mem_rvalid(mem_rvalid),
        .mem_rready(mem_rready),
        .mem_awaddr(mem_awaddr), .mem_awvalid(mem_awvalid), .mem_awready(mem_awready),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_wvalid(mem_wvalid),
        .mem_wready(mem_wready),
        .mem_bresp(mem_bresp), .mem_bvalid(mem_bvalid), .mem_bready(mem_bready)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    int unsigned n_checks, n_errors, n_done;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Memory contents are a pure function of the address.
    function automatic logic [DW-1:0] rd_data(input logic [AW-1:0] a);
        return {a, ~a};
    endfunction
    function automatic logic [1:0] rd_resp(input logic [AW-1:0] a);
        return a[4] ? RESP_SLVERR : RESP_OKAY;
    endfunction
    function automatic logic [1:0] wr_resp(input logic [AW-1:0] a);
        return a[5] ? RESP_SLVERR : RESP_OKAY;
    endfunction
    function automatic logic [AW-1:0] rand_addr();
        return {1'b1, 28'($urandom), 3'b000};
    endfunction

    // Agent state
    bit i_busy, i_ar_pend, l_busy, l_ar_pend, w_busy, w_aw_pend, w_w_pend, force_contest;
    logic [AW-1:0] i_addr, l_addr, w_addr, m_rd_addr, wb_addr;
    logic [DW-1:0] w_data;
    logic [SW-1:0] w_strb;
    int w_wdly, m_rd_lat, wb_lat;
    bit m_rd_busy, wb_aw, wb_w, wb_bv, wb_early;
    // Model state
    int m_cur, m_last;
    bit m_ar_sent, m_aw_sent, m_w_sent;
    // Per-cycle samples
    bit s_req_wr, s_req_i, s_req_l, s_ar, s_r, s_aw, s_w, s_b;
    bit a_ifu_ar, a_ifu_r, a_lsu_ar, a_lsu_r, a_lsu_aw, a_lsu_w, a_lsu_b;
    bit a_mem_ar, a_mem_r, a_mem_aw, a_mem_w, a_mem_b;
    logic [AW-1:0] s_mem_araddr, s_mem_awaddr;

    function automatic logic [11:0] obs_ctl();
        return {mem_arvalid, ifu_arready, lsu_arready, mem_rready, ifu_rvalid, lsu_rvalid,
                mem_awvalid, lsu_awready, mem_wvalid, lsu_wready, lsu_bvalid, mem_bready};
    endfunction

    task automatic edge_update();
        // Reference model: one transaction at a time, chosen by priority rules.
        if (m_cur == C_NONE) begin
            if (s_req_wr) m_cur = C_WR;
            else if (s_req_i && s_req_l) m_cur = (m_last == 0) ? C_RL : C_RI;
            else if (s_req_i) m_cur = C_RI;
            else if (s_req_l) m_cur = C_RL;
            if (m_cur == C_RI) m_last = 0;
            else if (m_cur == C_RL) m_last = 1;
        end else if (m_cur == C_WR) begin
            if (s_aw) m_aw_sent = 1;
            if (s_w) m_w_sent = 1;
            if (s_b) begin m_cur = C_NONE; m_aw_sent = 0; m_w_sent = 0; end
        end else begin
            if (s_ar) m_ar_sent = 1;
            if (s_r) begin m_cur = C_NONE; m_ar_sent = 0; end
        end
        // Masters
        if (i_busy && a_ifu_r && (!i_ar_pend || a_ifu_ar)) begin i_busy = 0; n_done++; end
        if (a_ifu_ar) i_ar_pend = 0;
        if (l_busy && a_lsu_r && (!l_ar_pend || a_lsu_ar)) begin l_busy = 0; n_done++; end
        if (a_lsu_ar) l_ar_pend = 0;
        if (w_busy) begin
            if (a_lsu_b && !w_aw_pend && !w_w_pend) begin w_busy = 0; n_done++; end
            if (a_lsu_aw) w_aw_pend = 0;
            if (a_lsu_w) w_w_pend = 0;
            if (w_wdly > 0) w_wdly--;
        end
        // Memory read side
        if (m_rd_busy) begin
            if (a_mem_r) m_rd_busy = 0;
            else if (m_rd_lat > 0) m_rd_lat--;
        end else if (a_mem_ar && !a_mem_r) begin
            m_rd_busy = 1;
            m_rd_addr = s_mem_araddr;
            m_rd_lat  = mem_rvalid ? 0 : int'($urandom_range(0, 3));
        end
        // Memory write side; sometimes raises B early, before W has arrived.
        if (a_mem_b) begin
            wb_aw = 0; wb_w = 0; wb_bv = 0;
        end else begin
            if (a_mem_aw) begin
                wb_aw = 1; wb_addr = s_mem_awaddr;
                wb_early = ($urandom_range(0, 3) == 0);
                wb_lat = int'($urandom_range(0, 2));
            end
            if (a_mem_w) wb_w = 1;
            if (!wb_bv && wb_aw && (wb_early || wb_w)) begin
                if (wb_lat == 0) wb_bv = 1;
                else wb_lat--;
            end
        end
    endtask

    task automatic drive_masters();
        if (!i_busy && (force_contest || $urandom_range(0, 2) == 0)) begin
            i_busy = 1; i_ar_pend = 1; i_addr = rand_addr();
        end
        if (!l_busy && (force_contest || $urandom_range(0, 2) == 0)) begin
            l_busy = 1; l_ar_pend = 1; l_addr = rand_addr();
        end
        if (!force_contest && !w_busy && $urandom_range(0, 4) == 0) begin
            w_busy = 1; w_aw_pend = 1; w_w_pend = 1; w_addr = rand_addr();
            w_wdly = int'($urandom_range(0, 2));
            w_data = {$urandom, $urandom}; w_strb = SW'($urandom);
        end
        force_contest = 0;
        ifu_arvalid = i_ar_pend;
        ifu_araddr  = i_ar_pend ? i_addr : rand_addr();
        ifu_rready  = ($urandom_range(0, 3) != 0);
        lsu_arvalid = l_ar_pend;
        lsu_araddr  = l_ar_pend ? l_addr : rand_addr();
        lsu_rready  = ($urandom_range(0, 3) != 0);
        lsu_awvalid = w_aw_pend;
        lsu_awaddr  = w_addr;
        lsu_wvalid  = w_w_pend && (w_wdly == 0);
        lsu_wdata   = w_data;
        lsu_wstrb   = w_strb;
        lsu_bready  = ($urandom_range(0, 3) != 0);
    endtask

    task automatic drive_mem();
        logic [AW-1:0] a;
        mem_arready = !m_rd_busy && ($urandom_range(0, 3) != 0);
        if (m_rd_busy) mem_rvalid = (m_rd_lat == 0);
        else mem_rvalid = mem_arvalid && mem_arready && ($urandom_range(0, 3) == 0);
        a = m_rd_busy ? m_rd_addr : mem_araddr;
        mem_rdata = mem_rvalid ? rd_data(a) : {$urandom, $urandom};
        mem_rresp = mem_rvalid ? rd_resp(a) : 2'($urandom);
        mem_awready = !wb_aw && ($urandom_range(0, 2) != 0);
        mem_wready  = !wb_w && ($urandom_range(0, 2) != 0);
        mem_bvalid  = wb_bv;
        mem_bresp   = wb_bv ? wr_resp(wb_addr) : 2'($urandom);
    endtask

    task automatic sample_check();
        bit both, e_arv, e_iar, e_lar, e_rr, e_irv, e_lrv, e_awv, e_awr, e_wv, e_wr, e_bv, e_br;
        both  = (m_cur == C_WR) && m_aw_sent && m_w_sent;
        e_arv = ((m_cur == C_RI && ifu_arvalid) || (m_cur == C_RL && lsu_arvalid)) && !m_ar_sent;
        e_iar = (m_cur == C_RI) && !m_ar_sent && mem_arready;
        e_lar = (m_cur == C_RL) && !m_ar_sent && mem_arready;
        e_rr  = (m_cur == C_RI) ? ifu_rready : (m_cur == C_RL) ? lsu_rready : 1'b0;
        e_irv = (m_cur == C_RI) && mem_rvalid;
        e_lrv = (m_cur == C_RL) && mem_rvalid;
        e_awv = (m_cur == C_WR) && lsu_awvalid && !m_aw_sent;
        e_awr = (m_cur == C_WR) && !m_aw_sent && mem_awready;
        e_wv  = (m_cur == C_WR) && lsu_wvalid && !m_w_sent;
        e_wr  = (m_cur == C_WR) && !m_w_sent && mem_wready;
        e_bv  = both && mem_bvalid;
        e_br  = both && lsu_bready;
        check("ctl", obs_ctl(),
              {e_arv, e_iar, e_lar, e_rr, e_irv, e_lrv, e_awv, e_awr, e_wv, e_wr, e_bv, e_br});
        if (e_arv) check("araddr", mem_araddr, (m_cur == C_RI) ? i_addr : l_addr);
        if (e_irv) check("ifu_r", {ifu_rdata, ifu_rresp}, {rd_data(i_addr), rd_resp(i_addr)});
        if (e_lrv) check("lsu_r", {lsu_rdata, lsu_rresp}, {rd_data(l_addr), rd_resp(l_addr)});
        if (e_awv) check("awaddr", mem_awaddr, w_addr);
        if (e_wv)  check("wdata", {mem_wdata, mem_wstrb}, {w_data, w_strb});
        if (e_bv)  check("bresp", lsu_bresp, wr_resp(w_addr));
        s_req_wr = lsu_awvalid && lsu_wvalid;
        s_req_i  = ifu_arvalid;
        s_req_l  = lsu_arvalid;
        s_ar = e_arv && mem_arready;
        s_r  = mem_rvalid && e_rr;
        s_aw = e_awv && mem_awready;
        s_w  = e_wv && mem_wready;
        s_b  = mem_bvalid && e_br;
        a_ifu_ar = ifu_arvalid && ifu_arready;  a_ifu_r = ifu_rvalid && ifu_rready;
        a_lsu_ar = lsu_arvalid && lsu_arready;  a_lsu_r = lsu_rvalid && lsu_rready;
        a_lsu_aw = lsu_awvalid && lsu_awready;  a_lsu_w = lsu_wvalid && lsu_wready;
        a_lsu_b  = lsu_bvalid && lsu_bready;
        a_mem_ar = mem_arvalid && mem_arready;  a_mem_r = mem_rvalid && mem_rready;
        a_mem_aw = mem_awvalid && mem_awready;  a_mem_w = mem_wvalid && mem_wready;
        a_mem_b  = mem_bvalid && mem_bready;
        s_mem_araddr = mem_araddr;
        s_mem_awaddr = mem_awaddr;
    endtask

    task automatic cycle();
        @(posedge aclk);
        edge_update();
        #1 drive_masters();
        #1 drive_mem();
        #1 sample_check();
    endtask

    // Asserts reset with whatever stimulus is active, checks the outputs
    // clear without a clock edge, then clears every agent and the model.
    task automatic do_reset();
        aresetn = 1'b0;
        #1;
        check("rst_ctl", obs_ctl(), '0);
        check("rst_rdata", {ifu_rdata, lsu_rdata}, '0);
        check("rst_wdata", mem_wdata, '0);
        check("rst_misc", {mem_araddr, mem_awaddr, mem_wstrb, ifu_rresp, lsu_rresp, lsu_bresp}, '0);
        {ifu_arvalid, ifu_rready, lsu_arvalid, lsu_rready, lsu_awvalid, lsu_wvalid} = '0;
        {lsu_bready, mem_arready, mem_rvalid, mem_awready, mem_wready, mem_bvalid} = '0;
        {ifu_araddr, lsu_araddr, lsu_awaddr} = '0;
        {lsu_wdata, lsu_wstrb, mem_rdata, mem_rresp, mem_bresp} = '0;
        {i_busy, i_ar_pend, l_busy, l_ar_pend, w_busy, w_aw_pend, w_w_pend} = '0;
        {m_rd_busy, wb_aw, wb_w, wb_bv, wb_early} = '0;
        {m_ar_sent, m_aw_sent, m_w_sent} = '0;
        {s_req_wr, s_req_i, s_req_l, s_ar, s_r, s_aw, s_w, s_b} = '0;
        {a_ifu_ar, a_ifu_r, a_lsu_ar, a_lsu_r, a_lsu_aw, a_lsu_w, a_lsu_b} = '0;
        {a_mem_ar, a_mem_r, a_mem_aw, a_mem_w, a_mem_b} = '0;
        w_wdly = 0; m_rd_lat = 0; wb_lat = 0;
        m_cur = C_NONE; m_last = 0;
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        aresetn = 1'b1;
        force_contest = 1;
    endtask

    initial begin
        bit hit;
        int unsigned done_mark;
        n_checks = 0; n_errors = 0; n_done = 0;
        aresetn = 1'b0;
        do_reset();
        repeat (1500) cycle();
        check("progress1", n_done > 100, 1'b1);

        hit = 0;
        for (int k = 0; k < 300 && !hit; k++) begin
            cycle();
            if (m_cur == C_RL) hit = 1;
        end
        check("reach_rd_lsu", hit, 1'b1);
        done_mark = n_done;
        do_reset();
        repeat (1000) cycle();
        check("progress2", (n_done - done_mark) > 60, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
